// File: rtl/ultrasonic_proximity_filter_pkg.sv
// Shared definitions for the ultrasonic proximity filter and its neighbours.
// The ranger and this block use the same count scale, so the default
// thresholds and timeout live here.
package ultrasonic_proximity_filter_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_AVG_LOG2    = 2;
  localparam int DEF_NEAR_THRESH = 15;
  localparam int DEF_FAR_THRESH  = 20;
  localparam int DEF_CONFIRM     = 2;
  localparam int DEF_TIMEOUT     = 1000;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_NEAR  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/ultrasonic_proximity_filter_pulse_window_avg.sv
// Sliding-window averager: circular sample buffer, running sum and fill count.
// avg_calc/calc_valid expose the average that will be registered on this edge
// so the downstream FSM can act on it in the same cycle as avg/avg_valid.
module pulse_window_avg
  import ultrasonic_proximity_filter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] avg_calc,
  output logic             calc_valid,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = WIDTH + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [WIDTH-1:0]    buffer [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [FILL_W-1:0]   fill;
  logic                full;

  // fill saturates at DEPTH, so its top bit alone marks a full window
  assign full       = fill[AVG_LOG2];
  assign sum_next   = sum + SUM_W'(sample) - SUM_W'(buffer[wr_ptr]);
  assign avg_calc   = sum_next[SUM_W-1:AVG_LOG2];
  assign calc_valid = sample_valid && (full || (fill == FILL_W'(DEPTH - 1)));

  // Window storage, running sum and registered average
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
      wr_ptr    <= '0;
      sum       <= '0;
      fill      <= '0;
      avg_valid <= 1'b0;
      if (!reset) begin
        avg <= '0;
      end
    end else begin
      avg_valid <= calc_valid;
      if (sample_valid) begin
        buffer[wr_ptr] <= sample;
        wr_ptr         <= wr_ptr + AVG_LOG2'(1);
        sum            <= sum_next;
        if (!full) begin
          fill <= fill + FILL_W'(1);
        end
      end
      if (calc_valid) begin
        avg <= avg_calc;
      end
    end
  end

endmodule

// File: rtl/ultrasonic_proximity_filter.sv
// Ultrasonic proximity filter: moving average of echo widths, debounced
// hysteretic proximity alert and a sensor-stall watchdog.
module ultrasonic_proximity_filter
  import ultrasonic_proximity_filter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int NEAR_THRESH = DEF_NEAR_THRESH,
  parameter int FAR_THRESH  = DEF_FAR_THRESH,
  parameter int CONFIRM     = DEF_CONFIRM,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic             pulse_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             alert,
  output logic             fault
);

  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int CONF_W = $clog2(CONFIRM + 1);

  state_t            state;
  logic [WD_W-1:0]   wd_count;
  logic [CONF_W-1:0] confirm;
  logic              wd_hit;
  logic              in_near;
  logic              qualify;
  logic              confirm_last;
  logic [WIDTH-1:0]  avg_calc;
  logic              calc_valid;

  pulse_window_avg #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk          (clk),
    .reset        (reset),
    .flush        (wd_hit),
    .sample       (pulse_in),
    .sample_valid (pulse_valid),
    .avg_calc     (avg_calc),
    .calc_valid   (calc_valid),
    .avg          (avg_out),
    .avg_valid    (avg_valid)
  );

  // A pulse on the would-be timeout cycle clears the count instead of tripping
  assign wd_hit       = !pulse_valid && (wd_count == WD_W'(TIMEOUT - 1));
  assign in_near      = (state == ST_NEAR);
  // FILL and FAULT evaluate their first average with the CLEAR rule
  assign qualify      = in_near ? (avg_calc >= WIDTH'(FAR_THRESH))
                                : (avg_calc <  WIDTH'(NEAR_THRESH));
  assign confirm_last = (confirm == CONF_W'(CONFIRM - 1));

  // Watchdog: counts idle cycles, saturating at TIMEOUT
  always_ff @(posedge clk) begin
    if (!reset || pulse_valid) begin
      wd_count <= '0;
    end else if (wd_count != WD_W'(TIMEOUT)) begin
      wd_count <= wd_count + WD_W'(1);
    end
  end

  // Hysteresis FSM with confirm counter and registered alert/fault
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_FILL;
      confirm <= '0;
      alert   <= 1'b0;
      fault   <= 1'b0;
    end else if (wd_hit) begin
      state   <= ST_FAULT;
      confirm <= '0;
      alert   <= 1'b0;
      fault   <= 1'b1;
    end else if (pulse_valid) begin
      fault <= 1'b0;
      if (calc_valid) begin
        if (qualify && confirm_last) begin
          state   <= in_near ? ST_CLEAR : ST_NEAR;
          alert   <= !in_near;
          confirm <= '0;
        end else begin
          state   <= in_near ? ST_NEAR : ST_CLEAR;
          confirm <= qualify ? confirm + CONF_W'(1) : '0;
        end
      end else begin
        state <= ST_FILL;
      end
    end
  end

endmodule

// File: doc/ultrasonic_proximity_filter.md
Name: ultrasonic_proximity_filter

Overview:
- Sits directly downstream of the ultrasonic ranger.
- Consumes each latched echo pulse width, which is a clock-cycle count, one strobe per measurement.
- Produces a 4-sample moving-average distance and a debounced proximity alert with hysteresis.
- Also runs a watchdog that flags a stalled or disconnected sensor.
- The helmet alert/haptic logic consumes alert and fault.

Parameters:
- WIDTH, 16, pulse width and average width in bits.
- AVG_LOG2, 2, log2 of the averaging window (4 samples).
- NEAR_THRESH, 15, average strictly below this counts as "near".
- FAR_THRESH, 20, average at or above this counts as "clear". Must satisfy FAR_THRESH >= NEAR_THRESH.
- CONFIRM, 2, consecutive qualifying averages required to change alert state. Must be >= 1.
- TIMEOUT, 1000, cycles without pulse_valid before fault asserts.

Ports:
- clk, input, 1, system clock. All logic on posedge.
- reset, input, 1, synchronous, active-low. 0 clears all state on the next posedge.
- pulse_in, input, WIDTH, echo pulse width in clk cycles.
- pulse_valid, input, 1, one-cycle strobe: pulse_in holds a new measurement.
- avg_out, output, WIDTH, registered moving average.
- avg_valid, output, 1, one-cycle strobe: avg_out updated.
- alert, output, 1, object near (debounced, hysteretic).
- fault, output, 1, sensor timeout.

Behaviour:
- Reset (reset==0 at posedge): all of the following clear, and pulse_valid is ignored during reset.
  - avg_out=0, avg_valid=0, alert=0, fault=0.
  - Window buffer, running sum (WIDTH+AVG_LOG2 bits), fill count, confirm counter and watchdog all 0.
  - State returns to FILL.
  - Reset mid-operation aborts everything with no partial output.
- Window update on each accepted pulse_valid:
  - sum_next = sum + pulse_in - oldest.
  - pulse_in overwrites the oldest entry; the write pointer wraps modulo 2^AVG_LOG2.
  - avg = sum_next >> AVG_LOG2 (truncating).
  - No overflow is possible by sum width.
- Latency: avg_out/avg_valid register on the same edge that samples pulse_valid, so they are visible one cycle later. avg_valid is never high two cycles in a row unless pulse_valid is.
- States:
  - FILL:
    - Fill count increments per sample.
    - avg_valid stays 0 until the 2^AVG_LOG2-th sample.
    - On that sample, avg_valid=1 and the state moves to CLEAR.
    - That first average is evaluated as a CLEAR-state sample (below).
  - CLEAR (alert=0):
    - On each avg_valid, if avg < NEAR_THRESH then confirm++, else confirm=0.
    - When confirm reaches CONFIRM: go to NEAR, alert=1 on that same edge, confirm=0.
  - NEAR (alert=1):
    - On each avg_valid, if avg >= FAR_THRESH then confirm++, else confirm=0.
    - When confirm reaches CONFIRM: go to CLEAR, alert=0, confirm=0.
    - Averages between the thresholds reset confirm in either state.
  - FAULT (fault=1, alert=0):
    - Entered from any state when the watchdog reaches TIMEOUT.
    - On entry, window, sum and fill count are flushed.
    - The next pulse_valid clears fault on that edge and is taken as sample 1 of FILL.
- Watchdog:
  - Increments every cycle without pulse_valid; clears on pulse_valid.
  - Saturates at TIMEOUT.
  - If pulse_valid arrives on the cycle the count would reach TIMEOUT, pulse_valid wins and fault stays 0.
- Boundary values:
  - pulse_in=0 and pulse_in=all-ones are legal samples.
  - avg == NEAR_THRESH counts as not-near.
  - avg == FAR_THRESH counts as clear.

Decomposition:
- Shared package holds:
  - State encoding localparams (FILL, CLEAR, NEAR, FAULT).
  - Default WIDTH/AVG_LOG2.
  - Default threshold and timeout constants, so the ranger and this block agree on the count scale.
- One sub-module, pulse_window_avg: circular buffer, write pointer, running sum, fill count, flush input, registered avg/avg_valid.
- The top level holds the hysteresis FSM, confirm counter and watchdog.

Test Plan:
- Reset, then 5 pulses of 10 spaced 50 cycles apart:
  - No avg_valid on pulses 1-3.
  - Pulse 4 gives avg_out=10, alert=0.
  - Pulse 5 gives alert=1.
- Hysteresis:
  - From NEAR with the window full of 17: alert stays 1.
  - Then pulses of 30: the first gives avg_out=20 with alert still 1; the second gives avg_out=23 and alert=0.
- Between thresholds: in NEAR, feed averages alternating 21 and 18. Confirm keeps clearing, so alert stays 1 indefinitely.
- Timeout:
  - 1000 idle cycles after a pulse gives fault=1 and alert=0 exactly at the 1000th cycle.
  - The next pulse clears fault on that edge, and 3 more pulses produce the first avg_valid.
- Race: pulse_valid lands on the cycle the watchdog would hit TIMEOUT, so fault never asserts.
- Width and reset:
  - 4 pulses of 0xFFFF give avg_out=0xFFFF.
  - reset=0 for 1 cycle while alert=1 gives all outputs 0 on the next edge, state FILL, and 4 fresh samples needed.
